defuse_scanner: RTL

- Downstream consumer of the defuse-field stage. Sequentially scans the per-level defuse (flag) array against the matching mine array, one cell per clock.
- Publishes the placed-flag count, remaining flags, and a sticky win indication to the game FSM and the HUD draw logic.
- Rescans continuously while enabled, so outputs track the flag arrays with a bounded lag.

---
 rtl/defuse_scanner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/defuse_scanner.sv
// Walks the selected board one cell per clock, tallying flags and flagged mines,
// then publishes flag count, remaining flags, over-flag and a sticky win per pass.
module defuse_scanner #(
    parameter int MINES_EASY   = 10,
    parameter int MINES_MEDIUM = 15,
    parameter int MINES_HARD   = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          level,
    input  logic [7:0][7:0]     defuse_arr_easy,
    input  logic [9:0][9:0]     defuse_arr_medium,
    input  logic [15:0][15:0]   defuse_arr_hard,
    input  logic [7:0][7:0]     mine_arr_easy,
    input  logic [9:0][9:0]     mine_arr_medium,
    input  logic [15:0][15:0]   mine_arr_hard,
    output logic [8:0]          flag_count,
    output logic [5:0]          flags_left,
    output logic                over_flagged,
    output logic                win,
    output logic                scan_done
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [1:0] LV_EASY   = 2'd0;
    localparam logic [1:0] LV_MEDIUM = 2'd1;
    localparam logic [1:0] LV_HARD   = 2'd2;

    function automatic logic [1:0] level_class(input logic [1:0] lv);
        case (lv)
            2'd3:    return LV_HARD;
            2'd2:    return LV_MEDIUM;
            default: return LV_EASY;
        endcase
    endfunction

    function automatic logic [3:0] last_index(input logic [1:0] cls);
        case (cls)
            LV_HARD:   return 4'd15;
            LV_MEDIUM: return 4'd9;
            default:   return 4'd7;
        endcase
    endfunction

    function automatic logic [5:0] mine_count(input logic [1:0] cls);
        case (cls)
            LV_HARD:   return 6'(MINES_HARD);
            LV_MEDIUM: return 6'(MINES_MEDIUM);
            default:   return 6'(MINES_EASY);
        endcase
    endfunction

    // Remaining flags clamp at zero once the player has placed M or more.
    function automatic logic [5:0] sat_left(input logic [8:0] flags, input logic [5:0] mines);
        logic [8:0] m9;
        m9 = {3'b000, mines};
        if (flags >= m9) return 6'd0;
        return 6'(m9 - flags);
    endfunction

    state_t      state, state_n;
    logic [3:0]  x, y;
    logic [8:0]  flag_acc, hit_acc;
    logic [1:0]  lvl_now, lvl_prev, lvl_lat;
    logic [3:0]  last_lat;
    logic [5:0]  m_lat;
    logic [5:0]  left_q;
    logic        scanned;
    logic        lvl_chg, cell_last, start, win_hit;
    logic        cell_flag, cell_mine;
    logic [8:0]  m9_lat;

    assign lvl_now   = level_class(level);
    assign lvl_chg   = (lvl_now != lvl_prev);
    assign cell_last = (x == last_lat) && (y == last_lat);
    assign m9_lat    = {3'b000, m_lat};
    assign win_hit   = (hit_acc == m9_lat) && (flag_acc == m9_lat);

    // A level change mid-scan restarts the pass regardless of enable.
    assign start = ((state == IDLE)   && enable) ||
                   ((state == SCAN)   && lvl_chg) ||
                   ((state == UPDATE) && enable);

    always_comb begin
        cell_flag = 1'b0;
        cell_mine = 1'b0;
        case (lvl_lat)
            LV_HARD: begin
                cell_flag = defuse_arr_hard[x][y];
                cell_mine = mine_arr_hard[x][y];
            end
            LV_MEDIUM: begin
                cell_flag = defuse_arr_medium[x][y];
                cell_mine = mine_arr_medium[x][y];
            end
            default: begin
                cell_flag = defuse_arr_easy[x[2:0]][y[2:0]];
                cell_mine = mine_arr_easy[x[2:0]][y[2:0]];
            end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = SCAN;
            SCAN:    if (!lvl_chg && cell_last) state_n = UPDATE;
            UPDATE:  state_n = enable ? SCAN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x            <= 4'd0;
            y            <= 4'd0;
            flag_acc     <= 9'd0;
            hit_acc      <= 9'd0;
            lvl_lat      <= LV_EASY;
            last_lat     <= 4'd7;
            m_lat        <= mine_count(LV_EASY);
            lvl_prev     <= lvl_now;
            scanned      <= 1'b0;
            flag_count   <= 9'd0;
            left_q       <= 6'd0;
            over_flagged <= 1'b0;
            win          <= 1'b0;
            scan_done    <= 1'b0;
        end else begin
            lvl_prev  <= lvl_now;
            scan_done <= 1'b0;

            if (start) begin
                x        <= 4'd0;
                y        <= 4'd0;
                flag_acc <= 9'd0;
                hit_acc  <= 9'd0;
                lvl_lat  <= lvl_now;
                last_lat <= last_index(lvl_now);
                m_lat    <= mine_count(lvl_now);
            end else if (state == SCAN) begin
                flag_acc <= flag_acc + {8'd0, cell_flag};
                hit_acc  <= hit_acc + {8'd0, cell_flag & cell_mine};
                if (y == last_lat) begin
                    y <= 4'd0;
                    x <= x + 4'd1;
                end else begin
                    y <= y + 4'd1;
                end
            end

            if (state == UPDATE) begin
                flag_count   <= flag_acc;
                left_q       <= sat_left(flag_acc, m_lat);
                over_flagged <= (flag_acc > m9_lat);
                scanned      <= 1'b1;
                scan_done    <= 1'b1;
            end

            if (lvl_chg)
                win <= 1'b0;
            else if ((state == UPDATE) && win_hit)
                win <= 1'b1;
        end
    end

    // Before the first completed pass the HUD shows the full mine count of the live level.
    assign flags_left = win ? 6'd0 : (scanned ? left_q : mine_count(lvl_now));

endmodule
